addsub_ctrl: RTL and testbench

ADDSUB_CTRL -- requirements
Module: addsub_ctrl

---
 rtl/addsub_pkg.sv | 30 +++
 rtl/addsub_res_fifo.sv | 62 ++++++
 rtl/addsub_ctrl.sv | 124 ++++++++++++
 tb/tb_addsub_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and defaults for the add/sub request controller.
// Holds FSM state enum, result record and default sizes.
package addsub_pkg;

  localparam int FIFO_DEPTH_DEF = 2;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic       zero;
  } res_t;

  function automatic res_t mk_res(
    input logic [7:0] sum,
    input logic       carry
  );
    res_t r;
    r.sum   = sum;
    r.carry = carry;
    r.zero  = (sum == 8'h00);
    return r;
  endfunction

endpackage

// File: rtl/addsub_res_fifo.sv
// Synchronous FIFO of add/sub results; head reads as 0 when empty.
// Ports: iClk, iRst_n, iPush/iData, iPop, oHead, oFull, oEmpty, oCount.
module addsub_res_fifo
  import addsub_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iPush,
  input  res_t                   iData,
  input  logic                   iPop,
  output res_t                   oHead,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  res_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign oFull  = (r_cnt == CW'(DEPTH));
  assign oEmpty = (r_cnt == '0);
  assign oCount = r_cnt;

  assign w_push = iPush && !oFull;
  assign w_pop  = iPop && !oEmpty;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst_n && w_push) begin
      r_mem[r_wr] <= iData;
    end
  end

  assign oHead = oEmpty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/addsub_ctrl.sv
// Request controller for an external add/sub unit with result buffer.
// Ports: req handshake, oA/oB/oMode to unit, iSum/iCarry back, rsp, oOpCnt.
module addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iReqValid,
  output logic             oReqReady,
  input  logic [7:0]       iReqA,
  input  logic [7:0]       iReqB,
  input  logic             iReqMode,
  output logic [7:0]       oA,
  output logic [7:0]       oB,
  output logic             oMode,
  input  logic [7:0]       iSum,
  input  logic             iCarry,
  output logic             oRspValid,
  input  logic             iRspReady,
  output logic [7:0]       oRspSum,
  output logic             oRspCarry,
  output logic             oRspZero,
  output logic [CNT_W-1:0] oOpCnt
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] DEPTH_V = FCW'(FIFO_DEPTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic             r_mode;
  logic [CNT_W-1:0] r_op_cnt;

  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [FCW-1:0] w_cnt;
  res_t           w_res;
  res_t           w_head;

  // Ready looks only at registered occupancy; a pop this cycle
  // does not open a slot until the next one.
  assign oReqReady = (r_state == IDLE) && (w_cnt < DEPTH_V);
  assign w_accept  = iReqValid && oReqReady;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = EXEC;
      end
      EXEC: begin
        w_push      = !w_full;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_a    <= iReqA;
      r_b    <= iReqB;
      r_mode <= iReqMode;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_op_cnt <= '0;
    end else if (w_push) begin
      r_op_cnt <= r_op_cnt + CNT_W'(1);
    end
  end

  assign w_res = mk_res(iSum, iCarry);

  addsub_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iPush  (w_push),
    .iData  (w_res),
    .iPop   (w_pop),
    .oHead  (w_head),
    .oFull  (w_full),
    .oEmpty (w_empty),
    .oCount (w_cnt)
  );

  assign oRspValid = !w_empty;
  assign w_pop     = oRspValid && iRspReady;

  assign oRspSum   = w_head.sum;
  assign oRspCarry = w_head.carry;
  assign oRspZero  = w_head.zero;

  assign oA     = r_a;
  assign oB     = r_b;
  assign oMode  = r_mode;
  assign oOpCnt = r_op_cnt;

endmodule

// File: tb/tb_addsub_ctrl.sv
// Scoreboard bench for addsub_ctrl with a behavioural add/sub unit.
// Ports: none (top-level bench).
module tb_addsub_ctrl;
  import addsub_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_a = '0;
  logic [7:0]    req_b = '0;
  logic          req_mode = 1'b0;
  logic [7:0]    oa;
  logic [7:0]    ob;
  logic          omode;
  logic [7:0]    u_sum;
  logic          u_carry;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_sum;
  logic          rsp_carry;
  logic          rsp_zero;
  logic [CW-1:0] op_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  int   ops   = 0;
  int   accepts = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  // External add/sub unit.
  logic [8:0] w_unit;
  assign w_unit  = omode ? ({1'b0, oa} - {1'b0, ob})
                         : ({1'b0, oa} + {1'b0, ob});
  assign u_sum   = w_unit[7:0];
  assign u_carry = w_unit[8];

  addsub_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iReqValid (req_valid),
    .oReqReady (req_ready),
    .iReqA     (req_a),
    .iReqB     (req_b),
    .iReqMode  (req_mode),
    .oA        (oa),
    .oB        (ob),
    .oMode     (omode),
    .iSum      (u_sum),
    .iCarry    (u_carry),
    .oRspValid (rsp_valid),
    .iRspReady (rsp_ready),
    .oRspSum   (rsp_sum),
    .oRspCarry (rsp_carry),
    .oRspZero  (rsp_zero),
    .oOpCnt    (op_cnt)
  );

  function automatic res_t model(int a, int b, bit m);
    res_t e;
    int   r;
    if (!m) begin
      r       = a + b;
      e.carry = (r > 255);
    end else begin
      r       = a - b;
      e.carry = (a < b);
    end
    e.sum  = 8'(r);
    e.zero = (e.sum == 8'd0);
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(output bit acc);
    acc = rst_n && req_valid && req_ready;
    if (acc) begin
      exp_q.push_back(model(int'(req_a), int'(req_b), req_mode));
      ops++;
      accepts++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic wait_ready();
    bit acc;
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      step(acc);
      t++;
    end
    if (!req_ready) chk("ready_timeout", 0, 1);
  endtask

  // Issue one op; returns after the buffer-write edge.
  task automatic do_op(logic [7:0] a, logic [7:0] b, logic m);
    bit acc;
    wait_ready();
    req_a     = a;
    req_b     = b;
    req_mode  = m;
    req_valid = 1'b1;
    step(acc);
    req_valid = 1'b0;
    if (!acc) chk("op_accept", 0, 1);
    step(acc);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_sum", int'(rsp_sum), int'(e.sum));
        chk("rsp_carry", int'(rsp_carry), int'(e.carry));
        chk("rsp_zero", int'(rsp_zero), int'(e.zero));
      end
    end
  end

  initial begin
    bit acc;
    int a0;

    rst_n = 1'b0;
    idle(3);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_cnt", int'(op_cnt), 0);
    chk("rst_oa", int'(oa), 0);
    chk("rst_sum", int'(rsp_sum), 0);
    rst_n = 1'b1;
    chk("rst_ready", int'(req_ready), 1);

    // Basic add with latency check.
    rsp_ready = 1'b1;
    req_a     = 8'h7F;
    req_b     = 8'h01;
    req_mode  = 1'b0;
    req_valid = 1'b1;
    step(acc);
    req_valid = 1'b0;
    chk("lat_accept", int'(acc), 1);
    chk("lat_exec_valid", int'(rsp_valid), 0);
    chk("lat_oa", int'(oa), 8'h7F);
    step(acc);
    chk("lat_valid", int'(rsp_valid), 1);
    chk("lat_sum", int'(rsp_sum), 8'h80);
    chk("lat_cnt", int'(op_cnt), 1);
    idle(1);

    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h03, 8'h05, 1'b1);
    do_op(8'h05, 8'h05, 1'b1);
    idle(2);
    chk("dir_cnt", int'(op_cnt), 4);
    chk("dir_drained", exp_q.size(), 0);
    chk("hold_oa", int'(oa), 8'h05);

    // Backpressure: buffer fills after two accepts.
    rsp_ready = 1'b0;
    a0        = accepts;
    req_valid = 1'b1;
    req_a     = 8'h11;
    req_b     = 8'h22;
    req_mode  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(acc);
      if (acc) begin
        req_a    = 8'($urandom);
        req_b    = 8'($urandom);
        req_mode = 1'($urandom);
      end
    end
    chk("bp_accepts", accepts - a0, 2);
    chk("bp_ready", int'(req_ready), 0);
    chk("bp_valid", int'(rsp_valid), 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(4);
    chk("bp_ready_back", int'(req_ready), 1);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_cnt", int'(op_cnt), 6);

    // Reset in EXEC drops the in-flight result.
    req_a     = 8'h10;
    req_b     = 8'h20;
    req_mode  = 1'b0;
    req_valid = 1'b1;
    step(acc);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    ops = 0;
    idle(1);
    chk("mid_valid", int'(rsp_valid), 0);
    chk("mid_cnt", int'(op_cnt), 0);
    chk("mid_oa", int'(oa), 0);
    chk("mid_ob", int'(ob), 0);
    chk("mid_sum", int'(rsp_sum), 0);
    rst_n = 1'b1;
    chk("mid_ready", int'(req_ready), 1);
    idle(2);
    chk("mid_no_rsp", int'(rsp_valid), 0);

    // Counter wrap over 17 random ops.
    for (int k = 0; k < 17; k++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom));
      chk("wrap_cnt", int'(op_cnt), (k + 1) % 16);
    end
    idle(2);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(3) != 0);
      if (!req_valid && $urandom_range(1) == 1) begin
        req_valid = 1'b1;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        req_mode  = 1'($urandom);
      end
      step(acc);
      if (acc) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(6);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_cnt", int'(op_cnt), ops % 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
